// File: rtl/decompression.sv
// Run-length decoder: expands {count, value} tokens into 16-bit samples packed two per 32-bit word.
// Optional feature macro: DECOMP_STATS_EN adds the out_words handshake counter port.
module decompression (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    input  logic        ready_out,
    output logic [1:0]  state_o
`ifdef DECOMP_STATS_EN
    ,
    output logic [31:0] out_words
`endif
);

    // Both sides are Avalon-ST: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, and data is held stable while valid && !ready.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] run_cnt_q;
    logic [15:0] value_q;
    logic [15:0] low_half_q;
    logic        half_full_q;
    logic [31:0] data_out_q;
    logic        valid_out_q;

    logic [15:0] tok_cnt;
    logic [15:0] tok_val;
    logic        adv;

    assign tok_cnt   = data_in[31:16];
    assign tok_val   = data_in[15:0];
    assign adv       = !valid_out_q || ready_out;
    assign ready_in  = (state_q == IDLE) && !rst;
    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign state_o   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            run_cnt_q   <= 16'h0;
            value_q     <= 16'h0;
            low_half_q  <= 16'h0;
            half_full_q <= 1'b0;
            data_out_q  <= 32'h0;
            valid_out_q <= 1'b0;
        end else begin
            // A consumed word retires here unless a new word is loaded below in the same cycle.
            if (valid_out_q && ready_out) begin
                valid_out_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        if (tok_cnt != 16'h0) begin
                            run_cnt_q <= tok_cnt;
                            value_q   <= tok_val;
                            state_q   <= EXPAND;
                        end else begin
                            state_q <= FLUSH;
                        end
                    end
                end
                EXPAND: begin
                    if (adv) begin
                        if (!half_full_q) begin
                            low_half_q  <= value_q;
                            half_full_q <= 1'b1;
                        end else begin
                            data_out_q  <= {value_q, low_half_q};
                            valid_out_q <= 1'b1;
                            half_full_q <= 1'b0;
                        end
                        run_cnt_q <= run_cnt_q - 16'd1;
                        if (run_cnt_q == 16'd1) begin
                            state_q <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    // End of stream pads a pending half word with zeros in the upper sample.
                    if (!half_full_q) begin
                        state_q <= IDLE;
                    end else if (adv) begin
                        data_out_q  <= {16'h0000, low_half_q};
                        valid_out_q <= 1'b1;
                        half_full_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef DECOMP_STATS_EN
    logic [31:0] out_words_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_words_q <= 32'h0;
        end else if (valid_out_q && ready_out) begin
            out_words_q <= out_words_q + 32'd1;
        end
    end

    assign out_words = out_words_q;
`endif

endmodule
